// File: rtl/mac_tcdm_responder_pkg.sv
// mac_package: shared constants and decoded-request type for the MAC TCDM responder
package mac_package;
  localparam logic [15:0] MAC_TCDM_RESP_LFSR_SEED = 16'hACE1;
  localparam int MAC_TCDM_DW = 32;
  localparam int MAC_TCDM_BE_W = MAC_TCDM_DW / 8;
  typedef struct packed {
    logic [7:0]               bank;
    logic [15:0]              row;
    logic                     wen;
    logic [MAC_TCDM_BE_W-1:0] be;
    logic [MAC_TCDM_DW-1:0]   data;
  } mac_tcdm_req_t;
endpackage

// File: rtl/hwpe_stream_intf_tcdm.sv
// hwpe_stream_intf_tcdm: TCDM request/response bundle between a master and a slave
interface hwpe_stream_intf_tcdm;
  logic        req;
  logic        gnt;
  logic [31:0] add;
  logic        wen;
  logic [3:0]  be;
  logic [31:0] data;
  logic [31:0] r_data;
  logic        r_valid;
  modport master (output req, add, wen, be, data, input gnt, r_data, r_valid);
  modport slave (input req, add, wen, be, data, output gnt, r_data, r_valid);
endinterface

// File: rtl/mac_tcdm_rr_arbiter.sv
// mac_tcdm_rr_arbiter: round-robin one-hot grant over N requesters with a registered priority pointer
module mac_tcdm_rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);
  localparam int PW = N > 1 ? $clog2(N) : 1;
  logic [PW-1:0] ptr_q, ptr_d;
  // first requester at or after the pointer wins; pointer moves just past the winner
  always_comb begin
    gnt = '0;
    ptr_d = ptr_q;
    for (int i = 0; i < N; i++) begin
      int idx;
      idx = (int'(ptr_q) + i) % N;
      if (en && gnt == '0 && req[idx[PW-1:0]]) begin
        gnt[idx[PW-1:0]] = 1'b1;
        ptr_d = idx + 1 == N ? '0 : idx[PW-1:0] + 1'b1;
      end
    end
  end
  // priority pointer register
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else ptr_q <= ptr_d;
  end
endmodule

// File: rtl/mac_tcdm_responder.sv
// mac_tcdm_responder: multi-port word-interleaved TCDM slave; MAC_TCDM_RESP_STALL_EN adds LFSR grant stalls
module mac_tcdm_responder
  import mac_package::*;
#(
  parameter int MP = 4,
  parameter int NB_BANKS = 4,
  parameter int NB_WORDS = 256,
  parameter int DATA_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  hwpe_stream_intf_tcdm.slave  tcdm [MP-1:0],
  output logic [MP-1:0]        flags_o
);
  localparam int BW = $clog2(NB_BANKS);
  localparam int BWE = BW > 0 ? BW : 1;
  localparam int RW = $clog2(NB_WORDS);
  localparam int HI = 2 + BW + RW;
  mac_tcdm_req_t dec [MP];
  logic [MP-1:0] req, gnt, unused_bits;
  logic [MP-1:0] bank_req [NB_BANKS];
  logic [MP-1:0] bank_gnt [NB_BANKS];
  logic [DATA_WIDTH-1:0] mem [NB_BANKS][NB_WORDS];
  logic [MP-1:0] r_valid_q, r_valid_d;
  logic [DATA_WIDTH-1:0] r_data_q [MP];
  logic [DATA_WIDTH-1:0] r_data_d [MP];
  logic stall, block;
  assign block = rst_i | clear_i | stall;
  assign flags_o = req & ~gnt;
  for (genvar g = 0; g < MP; g++) begin : g_port
    assign req[g] = tcdm[g].req;
    assign dec[g] = '{bank: 8'(tcdm[g].add[2 +: BWE]) & 8'(NB_BANKS - 1),
                      row: 16'(tcdm[g].add[2 + BW +: RW]),
                      wen: tcdm[g].wen, be: tcdm[g].be, data: tcdm[g].data};
    assign tcdm[g].gnt = gnt[g];
    assign tcdm[g].r_valid = r_valid_q[g];
    assign tcdm[g].r_data = r_data_q[g];
    assign unused_bits[g] = ^{tcdm[g].add[1:0], tcdm[g].add[31:HI], dec[g].row[15:RW]};
  end
  for (genvar b = 0; b < NB_BANKS; b++) begin : g_bank
    for (genvar p = 0; p < MP; p++) begin : g_req
      assign bank_req[b][p] = req[p] && dec[p].bank == 8'(b);
    end
    mac_tcdm_rr_arbiter #(.N(MP)) i_arb (
      .clk(clk_i), .rst(rst_i | clear_i), .en(~block), .req(bank_req[b]), .gnt(bank_gnt[b])
    );
  end
`ifdef MAC_TCDM_RESP_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;
  // Fibonacci LFSR, taps 16,14,13,11
  always_comb lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  // LFSR advances every cycle; its low bit blanks all grants
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) lfsr_q <= MAC_TCDM_RESP_LFSR_SEED;
    else lfsr_q <= lfsr_d;
  end
  assign stall = lfsr_q[0];
`else
  assign stall = 1'b0;
`endif
  // a port's grant comes only from its addressed bank; read data is captured for the next cycle
  always_comb begin
    gnt = '0;
    for (int b = 0; b < NB_BANKS; b++) gnt = gnt | bank_gnt[b];
    r_valid_d = gnt;
    for (int p = 0; p < MP; p++)
      r_data_d[p] = gnt[p] && dec[p].wen ? mem[dec[p].bank[BWE-1:0]][dec[p].row[RW-1:0]] : '0;
  end
  // one-cycle response pipeline
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_valid_q <= '0;
      for (int p = 0; p < MP; p++) r_data_q[p] <= '0;
    end else begin
      r_valid_q <= r_valid_d;
      for (int p = 0; p < MP; p++) r_data_q[p] <= r_data_d[p];
    end
  end
  // byte-enabled stores from the single granted port of each bank; storage is never reset
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < NB_BANKS; b++)
      for (int p = 0; p < MP; p++)
        for (int i = 0; i < DATA_WIDTH / 8; i++)
          if (bank_gnt[b][p] && !dec[p].wen && dec[p].be[i])
            mem[b][dec[p].row[RW-1:0]][8*i +: 8] <= dec[p].data[8*i +: 8];
  end
endmodule

// File: tb/tb_mac_tcdm_responder.sv
// tb_mac_tcdm_responder: directed self-checking bench for mac_tcdm_responder
module tb_mac_tcdm_responder;
  localparam int MP = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;
  logic [MP-1:0] req = '0;
  logic [MP-1:0] wen = '0;
  logic [31:0] add [MP];
  logic [31:0] wdata [MP];
  logic [3:0] be [MP];
  logic [MP-1:0] gnt, r_valid, flags;
  logic [31:0] r_data [MP];
  int vectors = 0;
  int miscompares = 0;
  hwpe_stream_intf_tcdm tcdm [MP-1:0] ();
  for (genvar g = 0; g < MP; g++) begin : g_conn
    assign tcdm[g].req = req[g];
    assign tcdm[g].add = add[g];
    assign tcdm[g].wen = wen[g];
    assign tcdm[g].be = be[g];
    assign tcdm[g].data = wdata[g];
    assign gnt[g] = tcdm[g].gnt;
    assign r_valid[g] = tcdm[g].r_valid;
    assign r_data[g] = tcdm[g].r_data;
  end
  mac_tcdm_responder #(.MP(MP), .NB_BANKS(4), .NB_WORDS(256), .DATA_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .tcdm(tcdm), .flags_o(flags)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    req = '0;
  endtask
  task automatic drive(input int p, input logic [31:0] a, input logic w, input logic [3:0] b, input logic [31:0] d);
    req[p] = 1'b1;
    add[p] = a;
    wen[p] = w;
    be[p] = b;
    wdata[p] = d;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    idle();
    step();
    step();
    #2;
    vectors++; if (r_valid !== 4'b0000) begin miscompares++; $display("FAIL reset_r_valid got %b exp 0000", r_valid); end
    vectors++; if (flags !== 4'b0000) begin miscompares++; $display("FAIL reset_flags got %b exp 0000", flags); end
    for (int p = 0; p < MP; p++) begin
      vectors++; if (r_data[p] !== 32'h0) begin miscompares++; $display("FAIL reset_r_data%0d got %h exp 0", p, r_data[p]); end
    end
    rst = 1'b0;
  endtask
  task automatic test_conflict();
    logic [3:0] exp_g;
    for (int p = 0; p < MP; p++) drive(p, 32'(p * 16), 1'b1, 4'hF, 32'h0);
    for (int k = 0; k < 6; k++) begin
      exp_g = 4'b0001 << (k % 4);
      #2;
      vectors++; if (gnt !== exp_g) begin miscompares++; $display("FAIL conflict_gnt c%0d got %b exp %b", k, gnt, exp_g); end
      vectors++; if (flags !== ~exp_g) begin miscompares++; $display("FAIL conflict_flags c%0d got %b exp %b", k, flags, ~exp_g); end
      step();
      vectors++; if (r_valid !== exp_g) begin miscompares++; $display("FAIL conflict_r_valid c%0d got %b exp %b", k, r_valid, exp_g); end
    end
    clear = 1'b1;
    #2;
    vectors++; if (gnt !== 4'b0000) begin miscompares++; $display("FAIL clear_gnt got %b exp 0000", gnt); end
    vectors++; if (flags !== 4'b1111) begin miscompares++; $display("FAIL clear_flags got %b exp 1111", flags); end
    step();
    clear = 1'b0;
    vectors++; if (r_valid !== 4'b0000) begin miscompares++; $display("FAIL clear_r_valid got %b exp 0000", r_valid); end
    #2;
    vectors++; if (gnt !== 4'b0001) begin miscompares++; $display("FAIL clear_ptr_gnt got %b exp 0001", gnt); end
    step();
    idle();
    step();
  endtask
  task automatic test_single();
    drive(0, 32'h10, 1'b0, 4'hF, 32'hDEADBEEF);
    #2;
    vectors++; if (gnt !== 4'b0001) begin miscompares++; $display("FAIL single_wr_gnt got %b exp 0001", gnt); end
    vectors++; if (flags !== 4'b0000) begin miscompares++; $display("FAIL single_wr_flags got %b exp 0000", flags); end
    step();
    drive(0, 32'h10, 1'b1, 4'hF, 32'h0);
    vectors++; if (r_valid !== 4'b0001) begin miscompares++; $display("FAIL single_wr_r_valid got %b exp 0001", r_valid); end
    vectors++; if (r_data[0] !== 32'h0) begin miscompares++; $display("FAIL single_wr_r_data got %h exp 00000000", r_data[0]); end
    #2;
    vectors++; if (gnt !== 4'b0001) begin miscompares++; $display("FAIL single_rd_gnt got %b exp 0001", gnt); end
    step();
    idle();
    vectors++; if (r_valid !== 4'b0001) begin miscompares++; $display("FAIL single_rd_r_valid got %b exp 0001", r_valid); end
    vectors++; if (r_data[0] !== 32'hDEADBEEF) begin miscompares++; $display("FAIL single_rd_r_data got %h exp deadbeef", r_data[0]); end
    step();
    vectors++; if (r_valid !== 4'b0000) begin miscompares++; $display("FAIL single_idle_r_valid got %b exp 0000", r_valid); end
  endtask
  task automatic test_byte_en();
    drive(2, 32'h20, 1'b0, 4'hF, 32'h11223344);
    step();
    drive(2, 32'h20, 1'b0, 4'b0101, 32'hAABBCCDD);
    step();
    drive(2, 32'h20, 1'b1, 4'hF, 32'h0);
    step();
    drive(2, 32'h20, 1'b0, 4'b0000, 32'hFFFFFFFF);
    vectors++; if (r_data[2] !== 32'h11BB33DD) begin miscompares++; $display("FAIL byte_en_r_data got %h exp 11bb33dd", r_data[2]); end
    step();
    drive(2, 32'h20, 1'b1, 4'hF, 32'h0);
    vectors++; if (r_valid !== 4'b0100) begin miscompares++; $display("FAIL be0_r_valid got %b exp 0100", r_valid); end
    step();
    idle();
    vectors++; if (r_data[2] !== 32'h11BB33DD) begin miscompares++; $display("FAIL be0_r_data got %h exp 11bb33dd", r_data[2]); end
    step();
  endtask
  task automatic test_no_conflict();
    for (int p = 0; p < MP; p++) drive(p, 32'(p * 4), 1'b0, 4'hF, 32'hC0DE0000 + 32'(p));
    #2;
    vectors++; if (gnt !== 4'b1111) begin miscompares++; $display("FAIL parallel_wr_gnt got %b exp 1111", gnt); end
    step();
    for (int p = 0; p < MP; p++) drive(p, 32'(p * 4), 1'b1, 4'hF, 32'h0);
    #2;
    vectors++; if (gnt !== 4'b1111) begin miscompares++; $display("FAIL parallel_rd_gnt got %b exp 1111", gnt); end
    vectors++; if (flags !== 4'b0000) begin miscompares++; $display("FAIL parallel_rd_flags got %b exp 0000", flags); end
    step();
    idle();
    vectors++; if (r_valid !== 4'b1111) begin miscompares++; $display("FAIL parallel_r_valid got %b exp 1111", r_valid); end
    for (int p = 0; p < MP; p++) begin
      vectors++; if (r_data[p] !== 32'hC0DE0000 + 32'(p)) begin miscompares++; $display("FAIL parallel_r_data%0d got %h exp %h", p, r_data[p], 32'hC0DE0000 + 32'(p)); end
    end
    step();
  endtask
  task automatic test_reset_mid();
    drive(1, 32'h40, 1'b0, 4'hF, 32'hCAFEF00D);
    step();
    drive(1, 32'h40, 1'b1, 4'hF, 32'h0);
    #2;
    vectors++; if (gnt !== 4'b0010) begin miscompares++; $display("FAIL rmid_rd_gnt got %b exp 0010", gnt); end
    step();
    rst = 1'b1;
    drive(0, 32'h40, 1'b0, 4'hF, 32'h0);
    #2;
    vectors++; if (gnt !== 4'b0000) begin miscompares++; $display("FAIL rmid_rst_gnt got %b exp 0000", gnt); end
    step();
    rst = 1'b0;
    vectors++; if (r_valid !== 4'b0000) begin miscompares++; $display("FAIL rmid_r_valid got %b exp 0000", r_valid); end
    for (int p = 0; p < MP; p++) drive(p, 32'h40, 1'b1, 4'hF, 32'h0);
    #2;
    vectors++; if (gnt !== 4'b0001) begin miscompares++; $display("FAIL rmid_ptr_gnt got %b exp 0001", gnt); end
    step();
    idle();
    vectors++; if (r_valid !== 4'b0001) begin miscompares++; $display("FAIL rmid_ret_r_valid got %b exp 0001", r_valid); end
    vectors++; if (r_data[0] !== 32'hCAFEF00D) begin miscompares++; $display("FAIL rmid_retained got %h exp cafef00d", r_data[0]); end
    step();
  endtask
  task automatic test_stall();
    logic [15:0] m;
    logic g;
    int done;
    int cyc;
    rst = 1'b1;
    idle();
    step();
    rst = 1'b0;
    m = 16'hACE1;
    for (int ph = 0; ph < 2; ph++) begin
      done = 0;
      cyc = 0;
      while (done < 64 && cyc < 1000) begin
        drive(0, 32'(done * 4), ph == 1, 4'hF, 32'h5A000000 + 32'(done));
        #2;
        g = gnt[0];
        vectors++; if (g !== ~m[0]) begin miscompares++; $display("FAIL stall_gnt ph%0d c%0d got %b exp %b", ph, cyc, g, ~m[0]); end
        step();
        m = {m[0] ^ m[2] ^ m[3] ^ m[5], m[15:1]};
        if (g === 1'b1) begin
          if (ph == 1) begin
            vectors++; if (r_data[0] !== 32'h5A000000 + 32'(done)) begin miscompares++; $display("FAIL stall_r_data %0d got %h exp %h", done, r_data[0], 32'h5A000000 + 32'(done)); end
          end
          done++;
        end
        cyc++;
      end
      vectors++; if (done != 64) begin miscompares++; $display("FAIL stall_timeout ph%0d got %0d exp 64", ph, done); end
    end
    idle();
    step();
  endtask
  initial begin
    for (int p = 0; p < MP; p++) begin
      add[p] = '0;
      wdata[p] = '0;
      be[p] = '0;
    end
    test_reset();
`ifdef MAC_TCDM_RESP_STALL_EN
    test_stall();
`else
    test_conflict();
    test_single();
    test_byte_en();
    test_no_conflict();
    test_reset_mid();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end
endmodule
